// File: rtl/io_event_ctrl.sv
// Debounced press/release event generator with a show-ahead event FIFO.
// Optional auto-repeat while a key is held: define IO_EVT_REPEAT_EN.
module io_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] in_code,
    input  logic       in_valid,
    output logic [1:0] evt_code,
    output logic       evt_release,
    output logic       evt_repeat,
    output logic       evt_valid,
    input  logic       evt_ready,
    input  logic       clr_ovf,
    output logic       overflow,
    output logic       busy
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 ||
        REPEAT_DELAY > 65535 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_param_err
        $error("io_event_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_REL_DB} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_cand, w_cand_nxt;
    logic        r_busy;
    logic        w_match;
    logic        w_push;
    logic        w_push_rel;
    logic        w_push_rep;

`ifdef IO_EVT_REPEAT_EN
    localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_PERIOD - 1);

    logic [15:0] r_rpt_cnt, w_rpt_cnt_nxt;
    logic        r_rpt_first, w_rpt_first_nxt;
`endif

    assign w_match = in_valid && (in_code == r_cand);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_push      = 1'b0;
        w_push_rel  = 1'b0;
        w_push_rep  = 1'b0;
`ifdef IO_EVT_REPEAT_EN
        // Timer restarts whenever we are not sitting in HELD with a matching input.
        w_rpt_cnt_nxt   = 16'd0;
        w_rpt_first_nxt = 1'b1;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_DEBOUNCE;
                    w_cand_nxt  = in_code;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_DEBOUNCE: begin
                if (!w_match) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_HELD;
                    w_push      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_HELD: begin
                if (!w_match) begin
                    w_state_nxt = S_REL_DB;
                    w_cnt_nxt   = 16'd0;
                end else begin
`ifdef IO_EVT_REPEAT_EN
                    if (r_rpt_cnt == (r_rpt_first ? RPT_FIRST : RPT_NEXT)) begin
                        w_push          = 1'b1;
                        w_push_rep      = 1'b1;
                        w_rpt_first_nxt = 1'b0;
                    end else begin
                        w_rpt_cnt_nxt   = r_rpt_cnt + 16'd1;
                        w_rpt_first_nxt = r_rpt_first;
                    end
`endif
                end
            end
            S_REL_DB: begin
                if (w_match) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_push      = 1'b1;
                    w_push_rel  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_cand  <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef IO_EVT_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt   <= 16'd0;
            r_rpt_first <= 1'b1;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_first <= w_rpt_first_nxt;
        end
    end
`endif

    logic [3:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0] r_count;
    logic        r_ovf;
    logic        w_empty, w_full, w_pop, w_wr, w_drop;
    logic [3:0]  w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW + 1)'(FIFO_DEPTH));
    assign w_pop   = evt_ready && !w_empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_cand, w_push_rel, w_push_rep};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head fields are masked by valid so stale storage never shows after reset.
    assign w_head      = r_mem[r_rd_ptr];
    assign evt_valid   = !w_empty;
    assign evt_code    = w_head[3:2] & {2{evt_valid}};
    assign evt_release = w_head[1] & evt_valid;
`ifdef IO_EVT_REPEAT_EN
    assign evt_repeat  = w_head[0] & evt_valid;
`else
    assign evt_repeat  = 1'b0;
`endif
    assign overflow    = r_ovf;
    assign busy        = r_busy;

endmodule

// File: tb/tb_io_event_ctrl.sv
// Randomised and directed bench for io_event_ctrl against a queue-based event model.
// Honours IO_EVT_REPEAT_EN the same way the design does.
module tb_io_event_ctrl;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int RD    = 10;
    localparam int RP    = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_code = 2'd0;
    logic       in_valid = 1'b0;
    logic [1:0] evt_code;
    logic       evt_release;
    logic       evt_repeat;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       overflow;
    logic       busy;

    io_event_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH     (DEPTH),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .evt_code   (evt_code),
        .evt_release(evt_release),
        .evt_repeat (evt_repeat),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: key phase, run lengths, hold age, event queue.
    typedef struct packed {
        logic [1:0] code;
        logic       rel;
        logic       rep;
    } evt_t;

    int         m_phase;   // 0 released, 1 confirming press, 2 pressed, 3 confirming release
    logic [1:0] m_key;
    int         m_run;
    int         m_age;
    evt_t       m_q[$];
    bit         m_ovf;

    task automatic model_reset();
        m_phase = 0;
        m_key   = 2'd0;
        m_run   = 0;
        m_age   = 0;
        m_q.delete();
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] c, input logic rdy, input logic clr);
        bit   same;
        bit   have_ev;
        bit   ovf_set;
        evt_t ev;
        same    = v && (c == m_key);
        have_ev = 1'b0;
        ovf_set = 1'b0;
        ev      = '0;
        if (m_phase == 0) begin
            if (v) begin
                m_phase = 1;
                m_key   = c;
                m_run   = 0;
            end
        end else if (m_phase == 1) begin
            if (!same) begin
                m_phase = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    m_phase = 2;
                    m_age   = 0;
                    have_ev = 1'b1;
                    ev      = '{code: m_key, rel: 1'b0, rep: 1'b0};
                end
            end
        end else if (m_phase == 2) begin
            if (!same) begin
                m_phase = 3;
                m_run   = 0;
            end else begin
`ifdef IO_EVT_REPEAT_EN
                m_age++;
                if (m_age >= RD && ((m_age - RD) % RP) == 0) begin
                    have_ev = 1'b1;
                    ev      = '{code: m_key, rel: 1'b0, rep: 1'b1};
                end
`endif
            end
        end else begin
            if (same) begin
                m_phase = 2;
                m_age   = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    m_phase = 0;
                    have_ev = 1'b1;
                    ev      = '{code: m_key, rel: 1'b1, rep: 1'b0};
                end
            end
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (have_ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        check_eq("evt_valid", 16'(evt_valid), 16'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check_eq("evt_code", 16'(evt_code), 16'(m_q[0].code));
            check_eq("evt_release", 16'(evt_release), 16'(m_q[0].rel));
            check_eq("evt_repeat", 16'(evt_repeat), 16'(m_q[0].rep));
        end
        check_eq("overflow", 16'(overflow), 16'(m_ovf));
        check_eq("busy", 16'(busy), 16'(m_phase != 0));
    endtask

    task automatic check_reset_state();
        check_eq("rst_evt_valid", 16'(evt_valid), 16'd0);
        check_eq("rst_evt_code", 16'(evt_code), 16'd0);
        check_eq("rst_evt_release", 16'(evt_release), 16'd0);
        check_eq("rst_evt_repeat", 16'(evt_repeat), 16'd0);
        check_eq("rst_overflow", 16'(overflow), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
    endtask

    task automatic cycle();
        logic       v;
        logic [1:0] c;
        logic       rdy;
        logic       clr;
        v   = in_valid;
        c   = in_code;
        rdy = evt_ready;
        clr = clr_ovf;
        @(posedge clk);
        model_edge(v, c, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic rdy, input logic clr, input int n);
        in_valid  = v;
        in_code   = c;
        evt_ready = rdy;
        clr_ovf   = clr;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called just after an edge: reset lands mid-cycle and is released mid-cycle.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_state();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single press of code 2, then its release.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 8);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 8);

        // Short pulse: no event, busy falls back.
        drive(1'b1, 2'd0, 1'b1, 1'b0, 2);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 6);

        // Glitch during release debounce, then a real release.
        drive(1'b1, 2'd1, 1'b1, 1'b0, 8);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2);
        drive(1'b1, 2'd1, 1'b1, 1'b0, 6);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 8);

        // Five events into a stalled FIFO, drain, then clear overflow.
        drive(1'b1, 2'd0, 1'b0, 1'b0, 6);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 6);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 6);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 6);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 6);
        check_eq("ovf_after_5", 16'(overflow), 16'd1);
        drive(1'b1, 2'd3, 1'b1, 1'b0, 6);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 8);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1);
        check_eq("ovf_cleared", 16'(overflow), 16'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2);

        // Reset while held with two queued events.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 6);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 6);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 6);
        check_eq("pre_rst_busy", 16'(busy), 16'd1);
        async_reset();
        drive(1'b1, 2'd3, 1'b1, 1'b0, 8);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 8);

        // Long hold of code 3 (auto-repeat when built in).
        drive(1'b1, 2'd3, 1'b1, 1'b0, 4 + 32);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 8);

        // Random segments of held inputs with random back-pressure.
        for (int seg = 0; seg < 200; seg++) begin
            logic       v;
            logic [1:0] c;
            int         len;
            v   = ($urandom_range(0, 3) != 0);
            c   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 14);
            in_valid = v;
            in_code  = c;
            for (int i = 0; i < len; i++) begin
                evt_ready = ($urandom_range(0, 3) == 0);
                clr_ovf   = ($urandom_range(0, 15) == 0);
                cycle();
            end
            if (seg % 67 == 66) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
